// File: rtl/counter_4b_checker_if.sv
// Observation bus for counter_4b_checker: counter stimulus and DUT outputs in, check results out.
interface counter_4b_checker_if #(
  parameter int ERR_W = 8,
  parameter int CHK_W = 16
);
  logic             enable;
  logic [1:0]       mode;
  logic [3:0]       D;
  logic [3:0]       dut_Q;
  logic             dut_load;
  logic             dut_rco;
  logic             chk_err;
  logic             chk_fail;
  logic [ERR_W-1:0] err_count;
  logic [CHK_W-1:0] chk_count;
  logic [5:0]       first_exp;
  logic [5:0]       first_got;

  modport master (
    output enable, mode, D, dut_Q, dut_load, dut_rco,
    input  chk_err, chk_fail, err_count, chk_count, first_exp, first_got
  );

  modport slave (
    input  enable, mode, D, dut_Q, dut_load, dut_rco,
    output chk_err, chk_fail, err_count, chk_count, first_exp, first_got
  );
endinterface

// File: rtl/counter_4b_checker.sv
// Cycle-accurate response checker for the 4-bit mode counter: reference model, compare, counters, first-fail capture.
// Build option COUNTER_4B_CHK_RESYNC_EN: after a mismatch the model's count is re-based on the DUT's count.
module counter_4b_checker #(
  parameter int ERR_W = 8,
  parameter int CHK_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  counter_4b_checker_if.slave  bus
);
  typedef struct packed {
    logic       rco;
    logic       load;
    logic [3:0] q;
  } obs_t;

  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, FAIL = 2'b10} state_t;

  state_t           state_q, state_d;
  obs_t             m_q, m_d, got;
  obs_t             fexp_q, fgot_q;
  logic [3:0]       base;
  logic             compare, mismatch, chk_err_q;
  logic [ERR_W-1:0] err_q;
  logic [CHK_W-1:0] cnt_q;

  assign got      = {bus.dut_rco, bus.dut_load, bus.dut_Q};
  assign compare  = (state_q != IDLE);
  // case-inequality so an X/Z on the DUT side is reported rather than masked
  assign mismatch = (m_q !== got);

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = RUN;
      RUN:     if (mismatch) state_d = FAIL;
      FAIL:    state_d = FAIL;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    base = m_q.q;
`ifdef COUNTER_4B_CHK_RESYNC_EN
    // next count advances from the DUT's value so one fault yields one error
    if (compare && mismatch) base = bus.dut_Q;
`endif
    m_d   = '0;
    m_d.q = base;
    if (bus.enable) begin
      case (bus.mode)
        2'b00: begin m_d.q = base + 4'd3; m_d.rco = (m_q.q >= 4'd13); end
        2'b01: begin m_d.q = base - 4'd1; m_d.rco = (m_q.q == 4'd0);  end
        2'b10: begin m_d.q = base + 4'd1; m_d.rco = (m_q.q == 4'd15); end
        default: begin m_d.q = bus.D; m_d.load = 1'b1; end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m_q       <= '0;
      chk_err_q <= 1'b0;
      err_q     <= '0;
      cnt_q     <= '0;
      fexp_q    <= '0;
      fgot_q    <= '0;
    end else begin
      m_q       <= m_d;
      chk_err_q <= compare && mismatch;
      if (compare && mismatch && !(&err_q)) err_q <= err_q + ERR_W'(1);
      if (compare && !(&cnt_q))             cnt_q <= cnt_q + CHK_W'(1);
      if (state_q == RUN && mismatch) begin
        fexp_q <= m_q;
        fgot_q <= got;
      end
    end
  end

  assign bus.chk_err   = chk_err_q;
  assign bus.chk_fail  = (state_q == FAIL);
  assign bus.err_count = err_q;
  assign bus.chk_count = cnt_q;
  assign bus.first_exp = fexp_q;
  assign bus.first_got = fgot_q;
endmodule
